// File: rtl/crc_stream_engine.sv
// Multi-byte-per-beat CRC engine: absorbs a keep-masked byte stream per frame and
// reports CRC, residue check and byte count through a held result handshake.
module crc_stream_engine #(
    parameter int          CRC_W   = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
    parameter int          NBYTES  = 4,
    parameter int          LEN_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_check,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [8*NBYTES-1:0]   s_data,
    input  logic [NBYTES-1:0]     s_keep,
    input  logic                  s_last,
    input  logic                  s_abort,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CRC_W-1:0]      crc_out,
    output logic                  crc_ok,
    output logic [LEN_W-1:0]      frame_len
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] x);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = x[CRC_W-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_W    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] POLY_R    = bit_rev(POLY[CRC_W-1:0]);
    localparam logic [CRC_W-1:0] INIT_W    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_W  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];
    localparam logic [CRC_W-1:0] CRC_ZERO  = {CRC_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_MAX   = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};

    // One byte through the bitwise LFSR; reflected mode shifts right with the mirrored polynomial.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] crc_in,
                                                  input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (REFLECT) begin
                fb = c[0] ^ data[i];
                c  = {1'b0, c[CRC_W-1:1]} ^ (fb ? POLY_R : CRC_ZERO);
            end else begin
                fb = c[CRC_W-1] ^ data[7-i];
                c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : CRC_ZERO);
            end
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               res_valid_q, res_valid_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;
    logic               crc_ok_q, crc_ok_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;

    logic               accept_s;
    logic               mode_eff_s;
    logic [CRC_W-1:0]   crc_beat_s;
    logic [LEN_W-1:0]   len_beat_s;

    assign s_ready    = ~rst & (state_q != ST_DONE);
    assign accept_s   = s_valid & s_ready;
    assign mode_eff_s = (state_q == ST_IDLE) ? mode_check : mode_q;

    // Absorb every enabled lane of the current beat, lane 0 first; the count saturates.
    always_comb begin
        crc_beat_s = (state_q == ST_IDLE) ? INIT_W : crc_q;
        len_beat_s = (state_q == ST_IDLE) ? LEN_ZERO : cnt_q;
        for (int l = 0; l < NBYTES; l++) begin
            crc_beat_s = s_keep[l] ? crc_byte(crc_beat_s, s_data[8*l +: 8]) : crc_beat_s;
            len_beat_s = len_beat_s +
                         {{(LEN_W-1){1'b0}}, (s_keep[l] & (len_beat_s != LEN_MAX))};
        end
    end

    // Frame state machine: next state, running register and result capture.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        res_valid_d = res_valid_q;
        crc_out_d   = crc_out_q;
        crc_ok_d    = crc_ok_q;
        frame_len_d = frame_len_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (s_abort) begin
                    state_d = ST_IDLE;
                    crc_d   = INIT_W;
                    cnt_d   = LEN_ZERO;
                end else if (accept_s) begin
                    mode_d = mode_eff_s;
                    crc_d  = crc_beat_s;
                    cnt_d  = len_beat_s;
                    if (s_last) begin
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                        crc_out_d   = crc_beat_s ^ XOROUT_W;
                        crc_ok_d    = mode_eff_s & (crc_beat_s == RESIDUE_W);
                        frame_len_d = len_beat_s;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                // Result is held until consumed; the register reloads for the next frame.
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    crc_d       = INIT_W;
                    cnt_d       = LEN_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
                crc_d       = INIT_W;
                cnt_d       = LEN_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT_W;
            cnt_q       <= LEN_ZERO;
            mode_q      <= 1'b0;
            res_valid_q <= 1'b0;
            crc_out_q   <= CRC_ZERO;
            crc_ok_q    <= 1'b0;
            frame_len_q <= LEN_ZERO;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            crc_out_q   <= crc_out_d;
            crc_ok_q    <= crc_ok_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign res_valid = res_valid_q;
    assign crc_out   = crc_out_q;
    assign crc_ok    = crc_ok_q;
    assign frame_len = frame_len_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: frame-level reference model plus directed frames with
// literal CRC expectations (CRC-32, saturating-count variant, CRC-16/CCITT-FALSE).
module tb_crc_stream_engine;

    logic        clk;
    logic        rst;
    logic        mode_check;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_abort;
    logic        res_ready;

    logic        s_ready, res_valid, crc_ok;
    logic [31:0] crc_out;
    logic [15:0] frame_len;

    logic        sat_ready, sat_valid, sat_ok;
    logic [31:0] sat_crc;
    logic [3:0]  sat_len;

    logic        mode16, s16_valid, s16_last, s16_abort, res16_ready;
    logic [7:0]  s16_data;
    logic [0:0]  s16_keep;
    logic        s16_ready, res16_valid, ok16;
    logic [15:0] crc16, len16;

    int n_pass  = 0;
    int n_total = 0;

    crc_stream_engine dut (
        .clk(clk), .rst(rst), .mode_check(mode_check), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_abort(s_abort),
        .res_valid(res_valid), .res_ready(res_ready), .crc_out(crc_out), .crc_ok(crc_ok),
        .frame_len(frame_len)
    );

    crc_stream_engine #(.LEN_W(4)) dut_sat (
        .clk(clk), .rst(rst), .mode_check(mode_check), .s_valid(s_valid), .s_ready(sat_ready),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_abort(s_abort),
        .res_valid(sat_valid), .res_ready(res_ready), .crc_out(sat_crc), .crc_ok(sat_ok),
        .frame_len(sat_len)
    );

    crc_stream_engine #(
        .CRC_W(16), .POLY(32'h00001021), .INIT(32'h0000FFFF), .XOROUT(32'h00000000),
        .REFLECT(1'b0), .RESIDUE(32'h00000000), .NBYTES(1), .LEN_W(16)
    ) dut16 (
        .clk(clk), .rst(rst), .mode_check(mode16), .s_valid(s16_valid), .s_ready(s16_ready),
        .s_data(s16_data), .s_keep(s16_keep), .s_last(s16_last), .s_abort(s16_abort),
        .res_valid(res16_valid), .res_ready(res16_ready), .crc_out(crc16), .crc_ok(ok16),
        .frame_len(len16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] rev_w(input logic [31:0] x, input int w);
        logic [31:0] o;
        o = 32'h0;
        for (int i = 0; i < w; i++) o[i] = x[w-1-i];
        return o;
    endfunction

    // Reference CRC as MSB-first polynomial division; reflected variants are obtained by
    // mirroring each input byte and the register, then mirroring the result back.
    function automatic logic [31:0] model_reg(input logic [7:0] q[$], input int w,
                                              input logic [31:0] poly, input logic [31:0] init,
                                              input bit refl);
        logic [31:0] mask, r, t;
        logic [7:0]  b;
        logic        fb;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        r    = refl ? rev_w(init, w) : (init & mask);
        foreach (q[k]) begin
            t = rev_w({24'h0, q[k]}, 8);
            b = refl ? t[7:0] : q[k];
            for (int i = 7; i >= 0; i--) begin
                fb = r[w-1] ^ b[i];
                r  = (r << 1) & mask;
                if (fb) r = r ^ (poly & mask);
            end
        end
        return refl ? rev_w(r, w) : r;
    endfunction

    // Frame-level model of the default-parameter engine, updated on each clock edge.
    bit          pend = 1'b0;
    bit          in_frame = 1'b0;
    bit          m_mode = 1'b0;
    logic [31:0] exp_crc = 32'h0;
    logic        exp_ok = 1'b0;
    int          exp_len = 0;
    logic [7:0]  mq[$];

    initial begin
        logic [31:0] r;
        forever begin
            @(posedge clk);
            if (rst) begin
                pend = 1'b0; in_frame = 1'b0; mq.delete();
            end else if (pend) begin
                if (res_ready) pend = 1'b0;
            end else if (s_abort) begin
                in_frame = 1'b0; mq.delete();
            end else if (s_valid) begin
                if (!in_frame) begin m_mode = mode_check; in_frame = 1'b1; end
                for (int l = 0; l < 4; l++) if (s_keep[l]) mq.push_back(s_data[8*l +: 8]);
                if (s_last) begin
                    r       = model_reg(mq, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1'b1);
                    exp_crc = r ^ 32'hFFFFFFFF;
                    exp_ok  = m_mode && (r == 32'hDEBB20E3);
                    exp_len = mq.size();
                    pend = 1'b1; in_frame = 1'b0; mq.delete();
                end
            end
        end
    end

    // Compare both stream instances against the model every cycle, mid-cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("s_ready", s_ready, !rst && !pend);
            chk("res_valid", res_valid, pend);
            chk("sat_ready", sat_ready, !rst && !pend);
            chk("sat_valid", sat_valid, pend);
            if (pend) begin
                chk("crc_out", crc_out, exp_crc);
                chk("crc_ok", crc_ok, exp_ok);
                chk("frame_len", frame_len, (exp_len > 65535) ? 65535 : exp_len);
                chk("sat_crc", sat_crc, exp_crc);
                chk("sat_ok", sat_ok, exp_ok);
                chk("sat_len", sat_len, (exp_len > 15) ? 15 : exp_len);
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame_a();
        beat(32'h34333231, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'h00000039, 4'h1, 1'b1);
    endtask

    initial begin
        logic [7:0] q16[$];
        rst = 1'b1; mode_check = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_keep = 4'h0;
        s_last = 1'b0; s_abort = 1'b0; res_ready = 1'b1;
        mode16 = 1'b0; s16_valid = 1'b0; s16_last = 1'b0; s16_abort = 1'b0;
        res16_ready = 1'b1; s16_data = 8'h0; s16_keep = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_rst", s_ready, 1'b0);
        rst = 1'b0;
        idle(1);
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_crc", crc_out, 32'h0);
        chk("rst_ok", crc_ok, 1'b0);
        chk("rst_len", frame_len, 16'd0);

        // Generate "123456789"
        frame_a();
        chk("gen_valid", res_valid, 1'b1);
        chk("gen_crc", crc_out, 32'hCBF43926);
        chk("gen_len", frame_len, 16'd9);
        chk("gen_ok", crc_ok, 1'b0);
        idle(1);

        // Check mode with trailer; mode_check dropped mid-frame must not matter
        mode_check = 1'b1;
        beat(32'h34333231, 4'hF, 1'b0);
        mode_check = 1'b0;
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1);
        chk("chk_ok", crc_ok, 1'b1);
        chk("chk_crc", crc_out, 32'h2144DF1C);
        chk("chk_len", frame_len, 16'd13);
        idle(1);

        // Single flipped data bit
        mode_check = 1'b1;
        beat(32'h34333230, 4'hF, 1'b0);
        mode_check = 1'b0;
        beat(32'h38373635, 4'hF, 1'b0);
        beat(32'hF4392639, 4'hF, 1'b0);
        beat(32'h000000CB, 4'h1, 1'b1);
        chk("flip_ok", crc_ok, 1'b0);
        idle(1);

        // Result held under backpressure while the next frame waits
        res_ready = 1'b0;
        frame_a();
        s_valid = 1'b1; s_data = 32'h34333231; s_keep = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", s_ready, 1'b0);
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_crc", crc_out, 32'hCBF43926);
            chk("hold_len", frame_len, 16'd9);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", s_ready, 1'b1);
        frame_a();
        chk("after_hold_crc", crc_out, 32'hCBF43926);
        idle(1);

        // Abort after two beats; the beat presented with abort is discarded
        beat(32'h34333231, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        s_abort = 1'b1; s_valid = 1'b1; s_data = 32'h00000039; s_keep = 4'h1; s_last = 1'b1;
        @(posedge clk); #1;
        s_abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        chk("abort_no_result", res_valid, 1'b0);
        idle(1);
        frame_a();
        chk("after_abort_crc", crc_out, 32'hCBF43926);
        chk("after_abort_len", frame_len, 16'd9);
        idle(1);

        // Sparse keep: bytes "1" and "2" on lanes 0 and 2
        beat(32'hAA32BB31, 4'h5, 1'b1);
        chk("sparse_len", frame_len, 16'd2);
        idle(1);

        // Empty frame
        beat(32'h12345678, 4'h0, 1'b1);
        chk("empty_crc", crc_out, 32'h00000000);
        chk("empty_len", frame_len, 16'd0);
        idle(1);

        // 20 bytes: the 4-bit counter instance saturates
        for (int i = 0; i < 5; i++)
            beat(32'h03020100 + 32'(i) * 32'h04040404, 4'hF, (i == 4));
        chk("long_len", frame_len, 16'd20);
        chk("sat_len_lit", sat_len, 4'hF);
        idle(1);

        // Reset in the middle of a frame
        beat(32'h34333231, 4'hF, 1'b0);
        beat(32'h38373635, 4'hF, 1'b0);
        rst = 1'b1; s_valid = 1'b1; s_data = 32'h00000039; s_keep = 4'h1; s_last = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", s_ready, 1'b0);
        chk("midrst_valid", res_valid, 1'b0);
        chk("midrst_crc", crc_out, 32'h0);
        chk("midrst_ok", crc_ok, 1'b0);
        chk("midrst_len", frame_len, 16'd0);
        s_valid = 1'b0; s_last = 1'b0; rst = 1'b0;
        idle(1);
        frame_a();
        chk("after_rst_crc", crc_out, 32'hCBF43926);
        idle(1);

        // CRC-16/CCITT-FALSE on the single-lane instance
        for (int i = 0; i < 9; i++) begin
            s16_valid = 1'b1; s16_keep = 1'b1; s16_data = 8'h31 + 8'(i); s16_last = (i == 8);
            q16.push_back(s16_data);
            chk("c16_ready", s16_ready, 1'b1);
            @(posedge clk); #1;
        end
        s16_valid = 1'b0; s16_last = 1'b0;
        chk("c16_valid", res16_valid, 1'b1);
        chk("c16_crc", crc16, 16'h29B1);
        chk("c16_model", crc16, model_reg(q16, 16, 32'h00001021, 32'h0000FFFF, 1'b0));
        chk("c16_len", len16, 16'd9);
        chk("c16_ok", ok16, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
